// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the fetch/data RAM port arbiter.
package ram_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_e;

  // Per-byte-lane merge for read-modify-write stores.
  function automatic logic [7:0] strb_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       strb);
    return strb ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_arbiter2.sv
// Two-requester round-robin; history only moves when both requesters collide.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic req_d,
  output logic gnt_i,
  output logic gnt_d
);

  grant_e last_grant_q;
  grant_e last_grant_d;

  always_comb begin
    gnt_i        = req_i & (~req_d | (last_grant_q == GNT_D));
    gnt_d        = req_d & (~req_i | (last_grant_q == GNT_I));
    last_grant_d = last_grant_q;
    if (req_i && req_d) begin
      last_grant_d = gnt_d ? GNT_D : GNT_I;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GNT_I;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares a 1R1W registered-read RAM between a fetch port and a byte-strobed data port,
// turning partial stores into a two-cycle read-modify-write.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_W-1:0]     i_req_addr,
  output logic                  i_rsp_valid,
  output logic [DATA_W-1:0]     i_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [ADDR_W-1:0]     d_req_addr,
  input  logic [DATA_W-1:0]     d_req_wdata,
  input  logic [DATA_W/8-1:0]   d_req_strb,
  output logic                  d_rsp_valid,
  output logic [DATA_W-1:0]     d_rsp_data,
  output logic [ADDR_W-1:0]     ram_raddr,
  input  logic [DATA_W-1:0]     ram_q,
  output logic                  ram_wen,
  output logic [ADDR_W-1:0]     ram_waddr,
  output logic [DATA_W-1:0]     ram_d
);

  localparam int STRB_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic [ADDR_W-1:0]   rmw_addr_q, rmw_addr_d;
  logic [DATA_W-1:0]   rmw_wdata_q, rmw_wdata_d;
  logic [STRB_W-1:0]   rmw_strb_q, rmw_strb_d;
  logic                i_rsp_valid_q, i_rsp_valid_d;
  logic                d_rd_q, d_rd_d;
  logic                d_wack_q, d_wack_d;

  logic                d_full, d_partial, d_uses_rd;
  logic                arb_req_i, arb_req_d, arb_gnt_i, arb_gnt_d;
  logic                d_acc;
  logic [DATA_W-1:0]   merged_word;

  for (genvar gi = 0; gi < STRB_W; gi++) begin : g_merge
    assign merged_word[gi*8 +: 8] = strb_merge(ram_q[gi*8 +: 8], rmw_wdata_q[gi*8 +: 8],
                                               rmw_strb_q[gi]);
  end

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (arb_req_i),
    .req_d (arb_req_d),
    .gnt_i (arb_gnt_i),
    .gnt_d (arb_gnt_d)
  );

  always_comb begin
    d_full    = d_req_we & (d_req_strb == {STRB_W{1'b1}});
    d_partial = d_req_we & ~d_full & (d_req_strb != '0);
    d_uses_rd = ~d_req_we | d_partial;

    // The data port stays off the read port while a store is being merged.
    arb_req_i = rst_n & i_req_valid;
    arb_req_d = rst_n & d_req_valid & d_uses_rd & (state_q == IDLE);

    i_req_ready = arb_gnt_i;
    d_req_ready = rst_n & (state_q == IDLE) & (d_uses_rd ? arb_gnt_d : d_req_valid);
    d_acc       = d_req_valid & d_req_ready;

    ram_raddr = raddr_q;
    if (arb_gnt_i) begin
      ram_raddr = i_req_addr;
    end else if (arb_gnt_d) begin
      ram_raddr = d_req_addr;
    end
    raddr_d = ram_raddr;

    ram_wen     = 1'b0;
    ram_waddr   = rmw_addr_q;
    ram_d       = merged_word;
    state_d     = state_q;
    rmw_addr_d  = rmw_addr_q;
    rmw_wdata_d = rmw_wdata_q;
    rmw_strb_d  = rmw_strb_q;

    case (state_q)
      IDLE: begin
        if (d_acc && d_full) begin
          ram_wen   = 1'b1;
          ram_waddr = d_req_addr;
          ram_d     = d_req_wdata;
        end else if (d_acc && d_partial) begin
          state_d     = RMW;
          rmw_addr_d  = d_req_addr;
          rmw_wdata_d = d_req_wdata;
          rmw_strb_d  = d_req_strb;
        end
      end
      RMW: begin
        ram_wen = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    i_rsp_valid_d = arb_gnt_i;
    d_rd_d        = d_acc & ~d_req_we;
    d_wack_d      = (d_acc & d_req_we & ~d_partial) | (state_q == RMW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      raddr_q       <= '0;
      rmw_addr_q    <= '0;
      rmw_wdata_q   <= '0;
      rmw_strb_q    <= '0;
      i_rsp_valid_q <= 1'b0;
      d_rd_q        <= 1'b0;
      d_wack_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      raddr_q       <= raddr_d;
      rmw_addr_q    <= rmw_addr_d;
      rmw_wdata_q   <= rmw_wdata_d;
      rmw_strb_q    <= rmw_strb_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      d_rd_q        <= d_rd_d;
      d_wack_q      <= d_wack_d;
    end
  end

  assign i_rsp_valid = i_rsp_valid_q;
  assign i_rsp_data  = ram_q;
  assign d_rsp_valid = d_rd_q | d_wack_q;
  assign d_rsp_data  = d_rd_q ? ram_q : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 1R1W read-before-write RAM.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [9:0]  i_req_addr;
  logic [31:0] i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [9:0]  d_req_addr;
  logic [31:0] d_req_wdata, d_rsp_data;
  logic [3:0]  d_req_strb;
  logic [9:0]  ram_raddr, ram_waddr;
  logic [31:0] ram_q, ram_d;
  logic        ram_wen;

  logic        tb_init;
  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;
  logic [31:0] mem [0:1023];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (tb_init) begin
      for (int a = 0; a < 1024; a++) mem[a] <= 32'h1000_0000 + a;
    end else begin
      if (bd_we) mem[bd_addr] <= bd_data;
      if (ram_wen) mem[ram_waddr] <= ram_d;
    end
    ram_q <= mem[ram_raddr];
  end

  ram_port_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_req_strb(d_req_strb),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .ram_raddr(ram_raddr), .ram_q(ram_q), .ram_wen(ram_wen),
    .ram_waddr(ram_waddr), .ram_d(ram_d)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_we = 1'b0; d_req_addr = '0;
    d_req_wdata = '0;   d_req_strb = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    tb_init = 1'b1;
    rst_n = 1'b0;
    i_req_valid = 1'b1;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_strb = 4'hF;
    tick();
    tick();
    n_total++; if (i_req_ready !== 1'b0) $display("FAIL reset_i_ready got=%b exp=0", i_req_ready); else n_pass++;
    n_total++; if (d_req_ready !== 1'b0) $display("FAIL reset_d_ready got=%b exp=0", d_req_ready); else n_pass++;
    n_total++; if (ram_wen !== 1'b0) $display("FAIL reset_ram_wen got=%b exp=0", ram_wen); else n_pass++;
    n_total++; if (i_rsp_valid !== 1'b0 || d_rsp_valid !== 1'b0)
      $display("FAIL reset_rsp_valid got=%b%b exp=00", i_rsp_valid, d_rsp_valid); else n_pass++;
    $display("[reset] ready i=%b d=%b wen=%b", i_req_ready, d_req_ready, ram_wen);
    idle_inputs();
    tb_init = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch_stream();
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin
        n_total++; if (i_rsp_valid !== 1'b1) $display("FAIL fetch_rsp_valid k=%0d got=%b exp=1", k-1, i_rsp_valid); else n_pass++;
        n_total++; if (i_rsp_data !== 32'h1000_0000 + (k-1))
          $display("FAIL fetch_rsp_data k=%0d got=%h exp=%h", k-1, i_rsp_data, 32'h1000_0000 + (k-1)); else n_pass++;
        $display("[fetch] addr=%0d data=%h", k-1, i_rsp_data);
      end
      if (k < 4) begin
        i_req_valid = 1'b1; i_req_addr = 10'(k);
      end else begin
        i_req_valid = 1'b0;
      end
      #1;
      if (k < 4) begin
        n_total++; if (i_req_ready !== 1'b1) $display("FAIL fetch_ready k=%0d got=%b exp=1", k, i_req_ready); else n_pass++;
      end
      tick();
    end
    n_total++; if (i_rsp_valid !== 1'b0) $display("FAIL fetch_rsp_idle got=%b exp=0", i_rsp_valid); else n_pass++;
  endtask

  task automatic test_arbitration();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    i_req_valid = 1'b1; i_req_addr = 10'h040;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 10'h041;
    #1;
    for (int k = 0; k < 4; k++) begin
      n_total++; if (d_req_ready !== ((k % 2) == 0)) $display("FAIL arb_d_ready k=%0d got=%b exp=%b", k, d_req_ready, (k % 2) == 0); else n_pass++;
      n_total++; if (i_req_ready !== ((k % 2) == 1)) $display("FAIL arb_i_ready k=%0d got=%b exp=%b", k, i_req_ready, (k % 2) == 1); else n_pass++;
      tick();
      if ((k % 2) == 0) begin
        n_total++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h1000_0041)
          $display("FAIL arb_d_rsp k=%0d got=%b/%h exp=1/10000041", k, d_rsp_valid, d_rsp_data); else n_pass++;
        n_total++; if (i_rsp_valid !== 1'b0) $display("FAIL arb_i_quiet k=%0d got=%b exp=0", k, i_rsp_valid); else n_pass++;
      end else begin
        n_total++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'h1000_0040)
          $display("FAIL arb_i_rsp k=%0d got=%b/%h exp=1/10000040", k, i_rsp_valid, i_rsp_data); else n_pass++;
        n_total++; if (d_rsp_valid !== 1'b0) $display("FAIL arb_d_quiet k=%0d got=%b exp=0", k, d_rsp_valid); else n_pass++;
      end
      $display("[arb] k=%0d i_rsp=%b d_rsp=%b", k, i_rsp_valid, d_rsp_valid);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_full_write();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 10'h010;
    d_req_wdata = 32'hDEAD_BEEF; d_req_strb = 4'hF;
    i_req_valid = 1'b1; i_req_addr = 10'h020;
    #1;
    n_total++; if (i_req_ready !== 1'b1 || d_req_ready !== 1'b1)
      $display("FAIL fw_ready got=i%b d%b exp=i1 d1", i_req_ready, d_req_ready); else n_pass++;
    n_total++; if (ram_wen !== 1'b1 || ram_waddr !== 10'h010 || ram_d !== 32'hDEAD_BEEF)
      $display("FAIL fw_ram_write got=%b/%h/%h exp=1/010/deadbeef", ram_wen, ram_waddr, ram_d); else n_pass++;
    tick();
    idle_inputs();
    n_total++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0)
      $display("FAIL fw_ack got=%b/%h exp=1/00000000", d_rsp_valid, d_rsp_data); else n_pass++;
    n_total++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'h1000_0020)
      $display("FAIL fw_fetch got=%b/%h exp=1/10000020", i_rsp_valid, i_rsp_data); else n_pass++;
    $display("[fw] ack=%b fetch=%h", d_rsp_valid, i_rsp_data);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 10'h010;
    #1;
    n_total++; if (d_req_ready !== 1'b1) $display("FAIL fw_rd_ready got=%b exp=1", d_req_ready); else n_pass++;
    tick();
    idle_inputs();
    n_total++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'hDEAD_BEEF)
      $display("FAIL fw_readback got=%b/%h exp=1/deadbeef", d_rsp_valid, d_rsp_data); else n_pass++;
    $display("[fw] readback=%h", d_rsp_data);
  endtask

  task automatic test_partial_write();
    bd_we = 1'b1; bd_addr = 10'h010; bd_data = 32'h1122_3344;
    tick();
    bd_we = 1'b0;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 10'h010;
    d_req_wdata = 32'hAABB_CCDD; d_req_strb = 4'b0101;
    #1;
    n_total++; if (d_req_ready !== 1'b1 || ram_wen !== 1'b0 || ram_raddr !== 10'h010)
      $display("FAIL pw_accept got=rdy%b wen%b raddr%h exp=rdy1 wen0 raddr010", d_req_ready, ram_wen, ram_raddr); else n_pass++;
    tick();
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 10'h099;
    d_req_wdata = 32'h5555_5555; d_req_strb = 4'hF;
    i_req_valid = 1'b1; i_req_addr = 10'h021;
    #1;
    n_total++; if (ram_wen !== 1'b1 || ram_waddr !== 10'h010 || ram_d !== 32'h11BB_33DD)
      $display("FAIL pw_merge got=%b/%h/%h exp=1/010/11bb33dd", ram_wen, ram_waddr, ram_d); else n_pass++;
    n_total++; if (d_req_ready !== 1'b0 || i_req_ready !== 1'b1 || d_rsp_valid !== 1'b0)
      $display("FAIL pw_rmw_ports got=drdy%b irdy%b dv%b exp=drdy0 irdy1 dv0", d_req_ready, i_req_ready, d_rsp_valid); else n_pass++;
    tick();
    idle_inputs();
    n_total++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h0)
      $display("FAIL pw_ack got=%b/%h exp=1/00000000", d_rsp_valid, d_rsp_data); else n_pass++;
    n_total++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'h1000_0021)
      $display("FAIL pw_fetch got=%b/%h exp=1/10000021", i_rsp_valid, i_rsp_data); else n_pass++;
    n_total++; if (mem[10'h010] !== 32'h11BB_33DD)
      $display("FAIL pw_mem got=%h exp=11bb33dd", mem[10'h010]); else n_pass++;
    $display("[pw] mem[010]=%h ack=%b", mem[10'h010], d_rsp_valid);
    tick();
    n_total++; if (d_rsp_valid !== 1'b0) $display("FAIL pw_ack_pulse got=%b exp=0", d_rsp_valid); else n_pass++;
  endtask

  task automatic test_same_addr();
    i_req_valid = 1'b1; i_req_addr = 10'h030;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 10'h030;
    d_req_wdata = 32'hCAFE_F00D; d_req_strb = 4'hF;
    #1;
    n_total++; if (i_req_ready !== 1'b1 || d_req_ready !== 1'b1)
      $display("FAIL sa_ready got=i%b d%b exp=i1 d1", i_req_ready, d_req_ready); else n_pass++;
    tick();
    idle_inputs();
    n_total++; if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'h1000_0030)
      $display("FAIL sa_old_data got=%b/%h exp=1/10000030", i_rsp_valid, i_rsp_data); else n_pass++;
    n_total++; if (mem[10'h030] !== 32'hCAFE_F00D)
      $display("FAIL sa_mem got=%h exp=cafef00d", mem[10'h030]); else n_pass++;
    $display("[sa] fetch=%h mem=%h", i_rsp_data, mem[10'h030]);
  endtask

  task automatic test_reset_in_rmw();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 10'h050;
    d_req_wdata = 32'h0000_00FF; d_req_strb = 4'b0001;
    #1;
    n_total++; if (d_req_ready !== 1'b1) $display("FAIL rr_accept got=%b exp=1", d_req_ready); else n_pass++;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    n_total++; if (ram_wen !== 1'b0 || d_rsp_valid !== 1'b0)
      $display("FAIL rr_drop got=wen%b dv%b exp=wen0 dv0", ram_wen, d_rsp_valid); else n_pass++;
    tick();
    n_total++; if (d_rsp_valid !== 1'b0 || mem[10'h050] !== 32'h1000_0050)
      $display("FAIL rr_mem got=dv%b %h exp=dv0 10000050", d_rsp_valid, mem[10'h050]); else n_pass++;
    rst_n = 1'b1;
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = 10'h050;
    #1;
    n_total++; if (d_req_ready !== 1'b1) $display("FAIL rr_idle got=%b exp=1", d_req_ready); else n_pass++;
    tick();
    idle_inputs();
    n_total++; if (d_rsp_valid !== 1'b1 || d_rsp_data !== 32'h1000_0050)
      $display("FAIL rr_readback got=%b/%h exp=1/10000050", d_rsp_valid, d_rsp_data); else n_pass++;
    $display("[rr] mem[050]=%h", d_rsp_data);
  endtask

  initial begin
    test_reset();
    test_fetch_stream();
    test_arbitration();
    test_full_write();
    test_partial_write();
    test_same_addr();
    test_reset_in_rmw();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
